// File: rtl/hssl_seq_pkg.sv
// Shared types and constants for the HSSL link bring-up sequencer.
// Optional build macro: HSSL_SEQ_STATS_EN (adds the retry statistics counter).
package hssl_seq_pkg;

    // Sequencer states; the codes are visible on state_out.
    typedef enum logic [2:0] {
        WAIT_CLK = 3'd0,
        TX_RST   = 3'd1,
        TX_WAIT  = 3'd2,
        RX_RST   = 3'd3,
        RX_WAIT  = 3'd4,
        HS_WAIT  = 3'd5,
        LINKED   = 3'd6,
        BACKOFF  = 3'd7
    } state_t;

    // Back-off lasts this many reset-pulse lengths.
    localparam int BACKOFF_MULT = 16;

    // Width of the retry statistics counter.
    localparam int STATS_W = 8;

    // Width of the shared per-state timeout counter.
    localparam int CNT_W = 32;

endpackage

// File: rtl/hssl_sync_bit.sv
// Two-flop synchronizer for one asynchronous level signal; clears to 0 on reset.
module hssl_sync_bit (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    // Two-stage capture into the freerun clock domain.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hssl_link_sequencer.sv
// Transceiver bring-up sequencer: tx datapath reset, rx datapath reset,
// handshake wait, link monitor, with timeouts and back-off retry.
// Optional build macro: HSSL_SEQ_STATS_EN adds retry_cnt_out.
module hssl_link_sequencer
    import hssl_seq_pkg::*;
#(
    parameter int PULSE_LEN    = 16,
    parameter int DONE_TIMEOUT = 1000000,
    parameter int HS_TIMEOUT   = 75000000
) (
    input  logic               freerun_clk_in,
    input  logic               reset_all_in,
    input  logic               tx_usrclk_active_in,
    input  logic               tx_reset_done_in,
    input  logic               rx_reset_done_in,
    input  logic               handshake_complete_in,
    output logic               tx_reset_datapath_out,
    output logic               rx_reset_datapath_out,
    output logic               link_up_out,
    output logic [2:0]         state_out
`ifdef HSSL_SEQ_STATS_EN
    ,
    output logic [STATS_W-1:0] retry_cnt_out
`endif
);

    localparam int BACKOFF_CYC = PULSE_LEN * BACKOFF_MULT;

    logic [3:0]       w_async;
    logic [3:0]       w_sync;
    logic             w_clk_ok;
    logic             w_tx_done;
    logic             w_rx_done;
    logic             w_hs_ok;
    logic             w_restart;
    state_t           w_next;
    logic [CNT_W-1:0] w_cnt_inc;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hs_lost;
    logic             r_tx_rst;
    logic             r_rx_rst;
    logic             r_link;

    assign w_async = {handshake_complete_in, rx_reset_done_in,
                      tx_reset_done_in, tx_usrclk_active_in};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
        hssl_sync_bit u_sync (
            .i_clk (freerun_clk_in),
            .i_rst (reset_all_in),
            .i_d   (w_async[gi]),
            .o_q   (w_sync[gi])
        );
    end

    assign w_clk_ok  = w_sync[0];
    assign w_tx_done = w_sync[1];
    assign w_rx_done = w_sync[2];
    assign w_hs_ok   = w_sync[3];

    // Counter saturates at all-ones so very long waits never wrap into a false timeout.
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state decision; losing the user clock overrides everything else.
    always_comb begin
        w_next    = r_state;
        w_restart = 1'b0;
        if (!w_clk_ok) begin
            w_next    = WAIT_CLK;
            w_restart = 1'b1;
        end else begin
            case (r_state)
                WAIT_CLK: w_next = TX_RST;
                TX_RST:   if (r_cnt >= CNT_W'(PULSE_LEN - 1)) w_next = TX_WAIT;
                TX_WAIT: begin
                    if (w_tx_done)                                w_next = RX_RST;
                    else if (r_cnt >= CNT_W'(DONE_TIMEOUT - 1))   w_next = BACKOFF;
                end
                RX_RST:   if (r_cnt >= CNT_W'(PULSE_LEN - 1)) w_next = RX_WAIT;
                RX_WAIT: begin
                    if (w_rx_done)                                w_next = HS_WAIT;
                    else if (r_cnt >= CNT_W'(DONE_TIMEOUT - 1))   w_next = BACKOFF;
                end
                // A handshake timeout only re-resets rx; tx is assumed healthy.
                HS_WAIT: begin
                    if (w_hs_ok)                                  w_next = LINKED;
                    else if (r_cnt >= CNT_W'(HS_TIMEOUT - 1))     w_next = RX_RST;
                end
                // Tolerate a single-cycle handshake glitch; drop on the second low cycle.
                LINKED:   if (!w_hs_ok && r_hs_lost) w_next = HS_WAIT;
                BACKOFF:  if (r_cnt >= CNT_W'(BACKOFF_CYC - 1)) w_next = TX_RST;
                default:  w_next = WAIT_CLK;
            endcase
        end
    end

    // State, shared timeout counter and registered outputs decoded from the next state.
    always_ff @(posedge freerun_clk_in or posedge reset_all_in) begin
        if (reset_all_in) begin
            r_state   <= WAIT_CLK;
            r_cnt     <= '0;
            r_hs_lost <= 1'b0;
            r_tx_rst  <= 1'b0;
            r_rx_rst  <= 1'b0;
            r_link    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= (w_restart || (w_next != r_state)) ? '0 : w_cnt_inc;
            r_hs_lost <= (r_state == LINKED) && (w_next == LINKED) && !w_hs_ok;
            r_tx_rst  <= (w_next == TX_RST);
            r_rx_rst  <= (w_next == RX_RST);
            r_link    <= (w_next == LINKED);
        end
    end

    assign tx_reset_datapath_out = r_tx_rst;
    assign rx_reset_datapath_out = r_rx_rst;
    assign link_up_out           = r_link;
    assign state_out             = r_state;

`ifdef HSSL_SEQ_STATS_EN
    logic               w_retry_ev;
    logic [STATS_W-1:0] r_retry;

    // A retry is any fresh entry to BACKOFF or a handshake timeout.
    always_comb begin
        w_retry_ev = ((w_next == BACKOFF) && (r_state != BACKOFF)) ||
                     ((r_state == HS_WAIT) && (w_next == RX_RST));
    end

    // Saturating retry counter, cleared only by reset.
    always_ff @(posedge freerun_clk_in or posedge reset_all_in) begin
        if (reset_all_in) begin
            r_retry <= '0;
        end else if (w_retry_ev && (r_retry != {STATS_W{1'b1}})) begin
            r_retry <= r_retry + STATS_W'(1);
        end
    end

    assign retry_cnt_out = r_retry;
`endif

endmodule

// File: doc/hssl_link_sequencer.md
HSSL_LINK_SEQUENCER -- requirements
Module: hssl_link_sequencer

Interface
REQ-001 SHALL have parameter PULSE_LEN, default 16: reset-pulse length in freerun cycles, range 1..255.
REQ-002 SHALL have parameter DONE_TIMEOUT, default 1000000: freerun cycles allowed for a reset-done to assert.
REQ-003 SHALL have parameter HS_TIMEOUT, default 75000000: freerun cycles allowed for handshake completion.
REQ-004 SHALL have port freerun_clk_in, input, 1: clock.
REQ-005 SHALL have port reset_all_in, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port tx_usrclk_active_in, input, 1: transceiver tx user clock running (async).
REQ-007 SHALL have port tx_reset_done_in, input, 1: transceiver tx reset done (async).
REQ-008 SHALL have port rx_reset_done_in, input, 1: transceiver rx reset done (async).
REQ-009 SHALL have port handshake_complete_in, input, 1: link handshake complete (async).
REQ-010 SHALL have port tx_reset_datapath_out, output, 1: tx datapath reset request to transceiver.
REQ-011 SHALL have port rx_reset_datapath_out, output, 1: rx datapath reset request to transceiver.
REQ-012 SHALL have port link_up_out, output, 1: link established.
REQ-013 SHALL have port state_out, output, 3: current FSM state code.

Function
REQ-014 SHALL pass every async input through a 2-flop synchronizer; all decisions use synchronized values (2-cycle latency).
REQ-015 SHALL implement states, codes in brackets: WAIT_CLK[0], TX_RST[1], TX_WAIT[2], RX_RST[3], RX_WAIT[4], HS_WAIT[5], LINKED[6], BACKOFF[7].
REQ-016 WAIT_CLK SHALL go to TX_RST when synchronized tx_usrclk_active is 1.
REQ-017 TX_RST SHALL hold tx_reset_datapath_out high for exactly PULSE_LEN cycles, then enter TX_WAIT.
REQ-018 TX_WAIT SHALL go to RX_RST on synchronized tx_reset_done; after DONE_TIMEOUT cycles without it, SHALL go to BACKOFF.
REQ-019 RX_RST and RX_WAIT SHALL mirror TX_RST and TX_WAIT using rx_reset_datapath_out and rx_reset_done; success SHALL enter HS_WAIT.
REQ-020 HS_WAIT SHALL go to LINKED on synchronized handshake_complete; after HS_TIMEOUT cycles without it, SHALL go to RX_RST (rx-only re-reset).
REQ-021 LINKED SHALL drive link_up_out=1 (registered, asserted the cycle state_out becomes 6).
REQ-022 LINKED SHALL, on loss of handshake_complete for 2 consecutive synchronized cycles, deassert link_up_out and enter HS_WAIT with the timeout counter cleared.
REQ-023 In any state, loss of synchronized tx_usrclk_active SHALL force WAIT_CLK and deassert both reset outputs and link_up_out next cycle; this has priority over every other transition.
REQ-024 BACKOFF SHALL wait PULSE_LEN*16 cycles, then enter TX_RST.
REQ-025 A single shared timeout counter SHALL clear on every state entry and saturate, never wrap.
REQ-026 tx_reset_datapath_out and rx_reset_datapath_out SHALL never be high in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 Reset SHALL set state WAIT_CLK and all outputs to 0: state_out=0, link_up_out=0, both reset outputs 0; synchronizers and counters SHALL be cleared.
REQ-029 Reset asserted mid-pulse SHALL terminate the pulse immediately (asynchronously).

Configuration
REQ-030 Macro HSSL_SEQ_STATS_EN, when defined, SHALL add output retry_cnt_out [7:0], which counts entries to BACKOFF plus HS_WAIT timeouts, saturates at 255, and is cleared only by reset.
REQ-031 Without HSSL_SEQ_STATS_EN, the port and counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-032 Package hssl_seq_pkg SHALL hold the state enum with its codes, the backoff multiplier (16), and the stats counter width (8).
REQ-033 Sub-module hssl_sync_bit (2-flop synchronizer, async-reset to 0) SHALL be instantiated once per async input.

Verification (PULSE_LEN=4, DONE_TIMEOUT=50, HS_TIMEOUT=100)
REQ-034 Nominal: usrclk_active=1, tx done 5 cycles after pulse, rx done 5 after pulse, handshake 10 later -> tx pulse 4 cycles, then rx pulse 4 cycles, non-overlapping; link_up_out=1.
REQ-035 tx_reset_done never asserts -> BACKOFF after 50 cycles in TX_WAIT; TX_RST re-entered after 64 cycles; retry_cnt_out=1 (stats build).
REQ-036 No handshake -> after 100 cycles in HS_WAIT, rx pulse only (tx_reset_datapath_out stays 0); retry_cnt_out increments.
REQ-037 In LINKED: handshake drops 1 cycle -> link stays up; drops 3 cycles -> link_up_out=0, state 5.
REQ-038 usrclk_active drops during RX_RST -> both resets low and state 0 within 3 cycles; restore -> sequence restarts at TX_RST.
REQ-039 reset_all_in pulsed mid TX_RST -> outputs 0 asynchronously; 300 forced retries -> retry_cnt_out holds 255.
